// File: rtl/cell_pos_reader_if.sv
// Bus bundle for the cell position reader: the cell-memory read port and
// the valid/ready particle stream toward the consumer.
interface cell_pos_reader_if #(
   parameter int DATA_WIDTH = 96,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_rden;
   logic                  mem_wren;
   logic [DATA_WIDTH-1:0] mem_q;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_pos;
   logic [ADDR_WIDTH-1:0] out_index;
   logic                  out_last;

   modport master (
      output mem_address, mem_rden, mem_wren,
      input  mem_q,
      output out_valid, out_pos, out_index, out_last,
      input  out_ready
   );

   modport slave (
      input  mem_address, mem_rden, mem_wren,
      output mem_q,
      input  out_valid, out_pos, out_index, out_last,
      output out_ready
   );
endinterface

// File: rtl/cell_pos_reader.sv
// Cell position reader: fetches the particle count from address 0, then
// streams addresses 1..count through a small credit-controlled FIFO so that
// the 2-cycle memory latency never drops data under backpressure.
module cell_pos_reader #(
   parameter int DATA_WIDTH   = 96,
   parameter int PARTICLE_NUM = 220,
   parameter int ADDR_WIDTH   = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] particle_count,
   cell_pos_reader_if.master     bus
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] MAX_CNT   = ADDR_WIDTH'(PARTICLE_NUM - 1);
   localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W:0]        DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_CNT, S_WAIT_CNT, S_STREAM, S_DRAIN, S_DONE
   } state_t;

   state_t state, state_n;

   logic                  wait_cnt;
   logic                  zero_cnt;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [ADDR_WIDTH-1:0] last_addr;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rden;
   logic                  issue;
   logic                  vld_p0, vld_p1;
   logic [ADDR_WIDTH-1:0] idx_p0, idx_p1;
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      fifo_count;
   logic [CNT_W:0]        occupancy;
   logic                  credit_ok;
   logic                  push, pop, last_hs;
   logic [ADDR_WIDTH-1:0] latched_cnt;

   logic [DATA_WIDTH-1:0] fifo_pos  [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_idx  [FIFO_DEPTH];
   logic                  fifo_last [FIFO_DEPTH];

   function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
      return (raw > MAX_CNT) ? MAX_CNT : raw;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // A FIFO slot is reserved when a read issues: words still in the memory
   // pipeline count against the depth, so a capture always finds room.
   assign occupancy = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(vld_p0) + (CNT_W + 1)'(vld_p1);
   assign credit_ok = occupancy < DEPTH_LIM;
   assign latched_cnt = clamp_count(bus.mem_q[ADDR_WIDTH-1:0]);

   assign bus.out_valid   = (fifo_count != '0);
   assign bus.out_pos     = bus.out_valid ? fifo_pos[rd_ptr] : '0;
   assign bus.out_index   = bus.out_valid ? fifo_idx[rd_ptr] : '0;
   assign bus.out_last    = bus.out_valid ? fifo_last[rd_ptr] : 1'b0;
   assign bus.mem_wren    = 1'b0;
   assign bus.mem_rden    = rden;
   assign bus.mem_address = rd_addr;

   assign push    = vld_p1;
   assign pop     = bus.out_valid & bus.out_ready;
   assign last_hs = pop & fifo_last[rd_ptr];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Next-state logic and per-state memory/handshake outputs.
   always_comb begin
      state_n = state;
      rden    = 1'b0;
      issue   = 1'b0;
      rd_addr = last_addr;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_n = S_RD_CNT;
         end
         S_RD_CNT: begin
            busy    = 1'b1;
            rden    = 1'b1;
            rd_addr = '0;
            state_n = S_WAIT_CNT;
         end
         S_WAIT_CNT: begin
            busy = 1'b1;
            // A zero count goes through DRAIN so it exits on the same rule.
            if (wait_cnt) state_n = (latched_cnt == '0) ? S_DRAIN : S_STREAM;
         end
         S_STREAM: begin
            busy = 1'b1;
            if (credit_ok) begin
               rden    = 1'b1;
               issue   = 1'b1;
               rd_addr = next_addr;
               if (next_addr == particle_count) state_n = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (last_hs || (zero_cnt && fifo_count == '0 && !vld_p0 && !vld_p1))
               state_n = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Control state: count latch, address sequencing, read pipeline valids, FIFO pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt       <= 1'b0;
         zero_cnt       <= 1'b0;
         particle_count <= '0;
         next_addr      <= '0;
         last_addr      <= '0;
         vld_p0         <= 1'b0;
         vld_p1         <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_count     <= '0;
      end else begin
         wait_cnt <= (state == S_WAIT_CNT) ? ~wait_cnt : 1'b0;
         if (state == S_WAIT_CNT && wait_cnt) begin
            particle_count <= latched_cnt;
            zero_cnt       <= (latched_cnt == '0);
            next_addr      <= ADDR_WIDTH'(1);
         end
         if (issue) next_addr <= next_addr + 1'b1;
         if (rden)  last_addr <= rd_addr;
         // p0: read issued this cycle; p1: data arrives on mem_q next cycle
         vld_p0 <= issue;
         vld_p1 <= vld_p0;
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      fifo_count <= fifo_count + 1'b1;
         else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      end
   end

   // Datapath: index travels with the read; word captured when it lands on mem_q.
   always_ff @(posedge clk) begin
      idx_p0 <= rd_addr;
      idx_p1 <= idx_p0;
      if (push) begin
         fifo_pos[wr_ptr]  <= bus.mem_q;
         fifo_idx[wr_ptr]  <= idx_p1;
         fifo_last[wr_ptr] <= (idx_p1 == particle_count);
      end
   end

endmodule

// File: tb/tb_cell_pos_reader.sv
// Bench for cell_pos_reader: memory model with 2-cycle latency, queue-based
// reference of the expected particle stream, cycle checks on key events.
module tb_cell_pos_reader;
   localparam int DW = 96;
   localparam int PN = 220;
   localparam int AW = 8;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic          done;
   logic [AW-1:0] particle_count;

   cell_pos_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   cell_pos_reader #(
      .DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .particle_count(particle_count), .bus(bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int start_cyc = 0;
   int ready_mode = 0;

   // Memory contents and 2-cycle read pipeline; idle slots carry junk data.
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rd_stage;
   always @(posedge clk) begin
      rd_stage  <= bus.mem_rden ? mem[bus.mem_address] : {$urandom, $urandom, $urandom};
      bus.mem_q <= rd_stage;
      cyc       <= cyc + 1;
   end

   // Reference stream: words 1..min(count, PN-1) in order, last flag on the final one.
   logic [DW-1:0] exp_pos [$];
   int            exp_idx [$];
   bit            exp_last[$];

   int  done_cnt, done_rel, hs_cnt, issued, popped, first_valid_rel;
   bit  valid_seen, stall_prev;
   logic [DW-1:0] prev_pos;
   logic [AW-1:0] prev_idx;
   logic          prev_last;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic build_exp(input int raw);
      int n;
      n = (raw > PN - 1) ? PN - 1 : raw;
      exp_pos.delete(); exp_idx.delete(); exp_last.delete();
      for (int i = 1; i <= n; i++) begin
         exp_pos.push_back(mem[i]);
         exp_idx.push_back(i);
         exp_last.push_back(i == n);
      end
   endtask

   task automatic load_cell(input int raw);
      logic [DW-1:0] w;
      w = {$urandom, $urandom, $urandom};
      w[AW-1:0] = AW'(raw);
      mem[0] = w;
      for (int i = 1; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
      build_exp(raw);
   endtask

   task automatic clear_stats();
      done_cnt = 0; done_rel = -1; hs_cnt = 0; issued = 0; popped = 0;
      first_valid_rel = -1; valid_seen = 0; stall_prev = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       bus.out_ready = 1'b0;
         1:       bus.out_ready = 1'b1;
         2:       bus.out_ready = 1'($urandom % 2);
         default: bus.out_ready = 1'(($urandom % 4) != 0);
      endcase
   endtask

   task automatic pulse_start();
      start = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      chk("done_seen", 128'(done_cnt != 0), 128'(1));
      repeat (3) tick();
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"},  128'(busy), 128'(0));
      chk({tag, "_done"},  128'(done), 128'(0));
      chk({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
      chk({tag, "_last"},  128'(bus.out_last), 128'(0));
      chk({tag, "_rden"},  128'(bus.mem_rden), 128'(0));
      chk({tag, "_wren"},  128'(bus.mem_wren), 128'(0));
      chk({tag, "_pos"},   128'(bus.out_pos), 128'(0));
      chk({tag, "_index"}, 128'(bus.out_index), 128'(0));
      chk({tag, "_pcount"},128'(particle_count), 128'(0));
      chk({tag, "_addr"},  128'(bus.mem_address), 128'(0));
   endtask

   // Stream monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mem_rden && bus.mem_address != '0) begin
            issued++;
            chk("credit", 128'((issued - popped) <= FD), 128'(1));
         end
         if (stall_prev) begin
            chk("hold_valid", 128'(bus.out_valid), 128'(1));
            chk("hold_pos",   128'(bus.out_pos),   128'(prev_pos));
            chk("hold_index", 128'(bus.out_index), 128'(prev_idx));
            chk("hold_last",  128'(bus.out_last),  128'(prev_last));
         end
         if (bus.out_valid && !valid_seen) begin
            valid_seen = 1;
            first_valid_rel = cyc - start_cyc;
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("word_expected", 128'(exp_pos.size() != 0), 128'(1));
            if (exp_pos.size() != 0) begin
               chk("pos",   128'(bus.out_pos),   128'(exp_pos.pop_front()));
               chk("index", 128'(bus.out_index), 128'(exp_idx.pop_front()));
               chk("last",  128'(bus.out_last),  128'(exp_last.pop_front()));
            end
            hs_cnt++;
            popped++;
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         prev_pos   = bus.out_pos;
         prev_idx   = bus.out_index;
         prev_last  = bus.out_last;
         if (done) begin
            done_cnt++;
            done_rel = cyc - start_cyc;
            chk("done_busy", 128'(busy), 128'(0));
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      start = 1'b0;
      bus.out_ready = 1'b0;
      clear_stats();
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk_idle_outputs("reset");

      // T1: three particles, consumer always ready
      load_cell(3);
      ready_mode = 1;
      clear_stats();
      pulse_start();
      chk("t1_busy", 128'(busy), 128'(1));
      wait_done(100);
      chk("t1_first_valid", 128'(first_valid_rel), 128'(7));
      chk("t1_done_cycle",  128'(done_rel), 128'(10));
      chk("t1_done_count",  128'(done_cnt), 128'(1));
      chk("t1_remaining",   128'(exp_pos.size()), 128'(0));
      chk("t1_pcount",      128'(particle_count), 128'(3));
      chk("t1_busy_after",  128'(busy), 128'(0));

      // T2: empty cell
      load_cell(0);
      clear_stats();
      pulse_start();
      wait_done(100);
      chk("t2_no_valid",   128'(valid_seen), 128'(0));
      chk("t2_done_cycle", 128'(done_rel), 128'(5));
      chk("t2_pcount",     128'(particle_count), 128'(0));

      // T3: random backpressure, fixed and random counts
      for (int k = 0; k < 4; k++) begin
         n = (k == 0) ? 10 : int'($urandom_range(1, 30));
         load_cell(n);
         ready_mode = 2;
         clear_stats();
         pulse_start();
         wait_done(1000);
         chk("t3_remaining",  128'(exp_pos.size()), 128'(0));
         chk("t3_done_count", 128'(done_cnt), 128'(1));
         chk("t3_pcount",     128'(particle_count), 128'(n));
      end

      // T4: count above the memory depth is clamped
      load_cell(250);
      ready_mode = 3;
      clear_stats();
      pulse_start();
      wait_done(3000);
      chk("t4_pcount",    128'(particle_count), 128'(PN - 1));
      chk("t4_remaining", 128'(exp_pos.size()), 128'(0));
      chk("t4_handshakes",128'(hs_cnt), 128'(PN - 1));

      // T5: reset after the third handshake, then a fresh stream
      load_cell(8);
      ready_mode = 1;
      clear_stats();
      pulse_start();
      n = 0;
      while (hs_cnt < 3 && n < 100) begin
         tick();
         n++;
      end
      chk("t5_hs3", 128'(hs_cnt), 128'(3));
      ready_mode = 0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      tick();
      chk_idle_outputs("t5_rst");
      rst = 1'b0;
      build_exp(8);
      ready_mode = 1;
      clear_stats();
      pulse_start();
      wait_done(100);
      chk("t5_remaining",  128'(exp_pos.size()), 128'(0));
      chk("t5_done_count", 128'(done_cnt), 128'(1));
      chk("t5_handshakes", 128'(hs_cnt), 128'(8));

      // T6: start re-pulsed while streaming and on the done cycle
      load_cell(6);
      ready_mode = 1;
      clear_stats();
      pulse_start();
      while (cyc - start_cyc < 5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (cyc - start_cyc < 13 && n < 50) begin
         tick();
         n++;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      chk("t6_done_count", 128'(done_cnt), 128'(1));
      chk("t6_done_cycle", 128'(done_rel), 128'(13));
      chk("t6_remaining",  128'(exp_pos.size()), 128'(0));
      chk("t6_handshakes", 128'(hs_cnt), 128'(6));
      chk("t6_busy",       128'(busy), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time guard in case a stream never completes.
   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
